// File: rtl/bp_pkg.sv
// Shared definitions for the valid/backpressure stream interface.
// Holds the default data width, the stream-transfer rule and the
// saturating increment that every stats counter on this interface uses.
package bp_pkg;

   localparam int DATA_W = 16;

   typedef logic [31:0] statCount_t;

   // A word moves across the interface only when valid is high and the
   // receiver is not stalling the sender.
   function automatic logic streamXfer(input logic valid, input logic backpressure);
      return valid & ~backpressure;
   endfunction

   // Counts up by one but sticks at the all-ones value instead of wrapping.
   function automatic statCount_t satInc32(input statCount_t value);
      return (value == '1) ? value : value + statCount_t'(1);
   endfunction

endpackage

// File: rtl/bp_fifo_mem.sv
// DEPTH x WIDTH register array for the sink FIFO.
// One synchronous write port and one asynchronous read port so the FIFO
// head can fall through to the output in the same cycle it is addressed.
module bp_fifo_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wrEn_i,
   input  logic [AW-1:0]    wrAddr_i,
   input  logic [WIDTH-1:0] wrData_i,
   input  logic [AW-1:0]    rdAddr_i,
   output logic [WIDTH-1:0] rdData_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage has no reset; stale contents are never visible because the
   // count in the parent gates out_valid.
   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         mem_q[wrAddr_i] <= wrData_i;
      end
   end

   assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/bp_sink_fifo.sv
// Receiving end of the valid/backpressure stream interface.
// Buffers producer results in a first-word-fall-through FIFO and drives the
// producer's stall input from registered state only, so in_valid never has a
// combinational path back into the producer's stall logic.
// Optional statistics (stall_cycles, max_level) are built when the macro
// BP_SINK_STATS_EN is defined; without it those ports do not exist.
module bp_sink_fifo
   import bp_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             backpressure_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
`ifdef BP_SINK_STATS_EN
   input  logic             out_ready,
   output logic [31:0]      stall_cycles,
   output logic [AW:0]      max_level
`else
   input  logic             out_ready
`endif
);

   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic          full;
   logic          push;
   logic          pop;

   assign full             = (count_q == FullCount);
   assign backpressure_out = areset | full;
   assign out_valid        = (count_q != '0);
   assign push             = streamXfer(in_valid, backpressure_out);
   assign pop              = out_valid & out_ready;

   bp_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk      (clk),
      .wrEn_i   (push),
      .wrAddr_i (wrPtr_q),
      .wrData_i (in_data),
      .rdAddr_i (rdPtr_q),
      .rdData_o (out_data)
   );

   // Next-state for pointers and occupancy; pointers wrap naturally because
   // DEPTH is a power of two, and a simultaneous push and pop leaves count alone.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + AW'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards everything stored.
   always_ff @(posedge clk) begin
      if (areset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Occupancy can never exceed the array size since a full FIFO refuses pushes.
   assert property (@(posedge clk) count_q <= FullCount);

`ifdef BP_SINK_STATS_EN
   statCount_t  stallCycles_q;
   logic [AW:0] maxLevel_q;

   // Count cycles where the producer wanted to send but was stalled, and
   // remember the highest occupancy seen since the last reset.
   always_ff @(posedge clk) begin
      if (areset) begin
         stallCycles_q <= '0;
         maxLevel_q    <= '0;
      end else begin
         if (in_valid && backpressure_out) begin
            stallCycles_q <= satInc32(stallCycles_q);
         end
         if (count_q > maxLevel_q) begin
            maxLevel_q <= count_q;
         end
      end
   end

   assign stall_cycles = stallCycles_q;
   assign max_level    = maxLevel_q;
`endif

endmodule

// File: tb/tb_bp_sink_fifo.sv
// Directed self-checking bench for bp_sink_fifo with DEPTH=16, WIDTH=16.
// Statistics checks are compiled in only when BP_SINK_STATS_EN is defined.
module tb_bp_sink_fifo;

   logic        clk;
   logic        areset;
   logic        in_valid;
   logic [15:0] in_data;
   logic        backpressure_out;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
`ifdef BP_SINK_STATS_EN
   logic [31:0] stall_cycles;
   logic [4:0]  max_level;
`endif

   int checks;
   int failures;

   bp_sink_fifo #(
      .WIDTH (16),
      .DEPTH (16)
   ) dut (
      .clk              (clk),
      .areset           (areset),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .backpressure_out (backpressure_out),
      .out_valid        (out_valid),
      .out_data         (out_data),
`ifdef BP_SINK_STATS_EN
      .out_ready        (out_ready),
      .stall_cycles     (stall_cycles),
      .max_level        (max_level)
`else
      .out_ready        (out_ready)
`endif
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic ready);
      in_valid  = valid;
      in_data   = data;
      out_ready = ready;
   endtask

   // Advance one clock and land 1 ns after the edge so outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset held three cycles while the producer offers data.
      areset = 1'b1;
      applyStimulus(1'b1, 16'h1234, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("reset_bp", 32'(backpressure_out), 32'd1);
      end
      areset = 1'b0;
      applyStimulus(1'b0, 16'h0000, 1'b0);
      #1;
      checkOutput("post_reset_valid", 32'(out_valid), 32'd0);
      checkOutput("post_reset_bp", 32'(backpressure_out), 32'd0);
      tick();
      checkOutput("reset_no_write", 32'(out_valid), 32'd0);

      // Single word through an empty FIFO.
      applyStimulus(1'b1, 16'hBEEF, 1'b0);
      tick();
      checkOutput("single_valid", 32'(out_valid), 32'd1);
      checkOutput("single_data", 32'(out_data), 32'hBEEF);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      tick();
      checkOutput("single_popped", 32'(out_valid), 32'd0);

      // Fill to full with words 0..15.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0);
         checkOutput("fill_bp_low", 32'(backpressure_out), 32'd0);
         tick();
      end
      checkOutput("full_bp", 32'(backpressure_out), 32'd1);
      checkOutput("full_head", 32'(out_data), 32'd0);

      // Word 16 is offered but must be held off while full.
      applyStimulus(1'b1, 16'd16, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("held_bp", 32'(backpressure_out), 32'd1);
         checkOutput("held_head", 32'(out_data), 32'd0);
      end

      // One pop opens a slot the following cycle; word 16 then goes in.
      applyStimulus(1'b1, 16'd16, 1'b1);
      tick();
      checkOutput("bubble_bp", 32'(backpressure_out), 32'd0);
      checkOutput("bubble_head", 32'(out_data), 32'd1);
      applyStimulus(1'b1, 16'd16, 1'b0);
      tick();
      checkOutput("refull_bp", 32'(backpressure_out), 32'd1);

      // Drain everything and confirm exact order 1..16.
      applyStimulus(1'b0, 16'h0000, 1'b1);
      for (int k = 1; k <= 16; k++) begin
         checkOutput("drain_valid", 32'(out_valid), 32'd1);
         checkOutput("drain_data", 32'(out_data), 32'(k));
         tick();
      end
      checkOutput("drain_empty", 32'(out_valid), 32'd0);

      // Continuous streaming for 40 words; pointers wrap twice.
      applyStimulus(1'b1, 16'd0, 1'b1);
      tick();
      for (int c = 1; c <= 40; c++) begin
         applyStimulus(1'b1, 16'(c), 1'b1);
         checkOutput("stream_valid", 32'(out_valid), 32'd1);
         checkOutput("stream_data", 32'(out_data), 32'(c - 1));
         checkOutput("stream_bp", 32'(backpressure_out), 32'd0);
         tick();
      end
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("stream_last", 32'(out_data), 32'd40);
      tick();
      checkOutput("stream_empty", 32'(out_valid), 32'd0);

      // Reset mid-operation discards stored entries.
      applyStimulus(1'b1, 16'hAAAA, 1'b0);
      tick();
      checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
      areset = 1'b1;
      applyStimulus(1'b0, 16'h0000, 1'b0);
      tick();
      areset = 1'b0;
      #1;
      checkOutput("mid_reset_valid", 32'(out_valid), 32'd0);

`ifdef BP_SINK_STATS_EN
      checkOutput("stats_clear_stall", stall_cycles, 32'd0);
      checkOutput("stats_clear_max", 32'(max_level), 32'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      checkOutput("stats_stall10", stall_cycles, 32'd10);
      checkOutput("stats_max16", 32'(max_level), 32'd16);
      force dut.stallCycles_q = 32'hFFFF_FFFE;
      #1;
      release dut.stallCycles_q;
      tick();
      checkOutput("stats_sat_reach", stall_cycles, 32'hFFFF_FFFF);
      tick();
      checkOutput("stats_sat_hold", stall_cycles, 32'hFFFF_FFFF);
      areset = 1'b1;
      applyStimulus(1'b0, 16'h0000, 1'b0);
      tick();
      areset = 1'b0;
      checkOutput("stats_reset_stall", stall_cycles, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
